byte_unstuffer: RTL and testbench
=================================

# byte_unstuffer

Receive-side counterpart of the JPEG entropy-stream byte stuffer. It takes a packed 16-bit entropy-coded-segment stream and removes the 0x00 stuffed after every 0xFF data byte. It detects the terminating marker (0xFF followed by a non-zero, non-0xFF byte) and repacks the surviving bytes into 16-bit output words. It sits between the bitstream fetch/DMA front end and the Huffman decoder.

## Interface
- No parameters.
- clk  input  1  clock; all state on posedge.
- rst  input  1  reset, asynchronous, active-high.
- ena_in  input  1  upstream word valid.
- rdy_out  output  1  ready to accept an upstream word; combinational.
- in  input  16  stream word; in[15:8] is the earlier byte.
- in_valid  input  2  2'b11 means both bytes valid; 2'b10 means only in[15:8] is valid (last word).
- flush  input  1  end of input without a marker; level, held until done.
- ena_out  output  1  output word valid (registered).
- rdy_in  input  1  downstream ready.
- out  output  16  unstuffed word; out[15:8] is the earlier byte.
- out_valid  output  2  2'b11 for full words; 2'b10 only for the final or partial word (lower byte 0x00).
- marker  output  8  second byte of the terminating marker.
- marker_valid  output  1  marker holds a captured marker code.
- done  output  1  stream finished; sticky until rst.
- err  output  1  sticky; set when a dangling 0xFF is seen at flush.

## Operation
- State: `hold[7:0]`/`hold_v` (pending output byte), `ff_pend` (the last consumed byte was 0xFF), FSM state, output register.
- FSM states:
  - RUN (reset state).
  - DRAIN: emit the last held byte.
  - DONE: terminal.
- A word is accepted when `ena_in && rdy_out`. `rdy_out = (state==RUN) && (!ena_out || rdy_in)`.
- Bytes are processed upper byte then lower byte. Only bytes flagged in in_valid are processed. Per byte b:
  - If `ff_pend` and b==0x00: emit 0xFF and clear `ff_pend`.
  - If `ff_pend` and b==0xFF: fill byte. The earlier 0xFF is dropped and `ff_pend` stays set.
  - If `ff_pend` and b is any other value: marker detected. `marker<=b` and `marker_valid<=1`. Any later byte in the same word is discarded. Go to DRAIN.
  - If not `ff_pend` and b==0xFF: set `ff_pend`; nothing is emitted.
  - Otherwise emit b.
- Packing: available bytes = `hold_v` + bytes emitted (0..2).
  - 2 or more available: load the output register with the first two and `ena_out<=1`. A third byte goes to `hold`.
  - Fewer than 2: update `hold`/`hold_v`.
- Flush: sampled in RUN on cycles with no accepted word. Go to DRAIN. If `ff_pend` is set, the 0xFF is dropped and `err<=1`.
- DRAIN: once the output register is free:
  - if `hold_v`, load `{hold,8'h00}` with out_valid 2'b10;
  - then enter DONE, with `done<=1`.
  - If `!hold_v`, go to DONE directly.
- DONE: `rdy_out=0`. Outputs are frozen, except that the last word drains normally. Only rst leaves DONE.

## Timing
- Reset values:
  - ena_out=0, out=0, out_valid=0, marker=0, marker_valid=0, done=0, err=0.
  - hold_v=0, ff_pend=0, state=RUN.
  - rdy_out=1 as soon as rst deasserts.
- Latency: a word accepted in cycle n appears on out in cycle n+1 when it completes a pair.
- Throughput: one word per cycle when rdy_in stays high.
- Backpressure: while `ena_out && !rdy_in`, out/out_valid hold stable and rdy_out=0. No byte is lost or duplicated.
- A marker split across words (0xFF in the lower byte, code in the next word's upper byte) is detected on the second accept.
- marker_valid and DRAIN entry occur in the cycle after the accept.
- done rises in the cycle after the partial word is taken (`ena_out && rdy_in`), or in the cycle after DRAIN entry if no byte is held.
- flush and ena_in in the same cycle: the word is accepted first and flush is acted on in a later cycle.
- Async rst in any state, including DRAIN with `ena_out` high, clears everything immediately. The held word is dropped.

## Configuration
- `BYTE_UNSTUFFER_RST_PASS_EN` defined:
  - Markers 0xD0–0xD7 (RSTn) do not terminate the stream.
  - On detection, `{hold,8'h00}` is emitted with out_valid 2'b10 if `hold_v`, and hold is cleared.
  - Outputs `rstm[2:0]` (n) and `rstm_valid` pulse for one cycle together with that load, or alone if nothing is held.
  - Bytes after RSTn in the same word continue normally.
  - The state stays RUN and marker/marker_valid are untouched.
- Undefined: RSTn is treated as any other marker (terminate, DRAIN), and the rstm ports are absent.

## Test plan
- Words 0x12FF, 0x0034 (11), then flush:
  - out 0x12FF/11, then 0x3400/10;
  - done=1, marker_valid=0, err=0.
- Words 0xFF00, 0xFF00:
  - a single out 0xFFFF/11;
  - hold_v=0 afterwards.
- Words 0xABFF, 0xD9EE:
  - marker=0xD9, marker_valid=1; 0xEE discarded;
  - out 0xAB00/10, then done=1, rdy_out=0.
- Backpressure: 0x0102, 0x0304 with rdy_in low for 5 cycles:
  - out holds 0x0102 and rdy_out=0 throughout;
  - then 0x0304 appears; no loss.
- Words 0x11FF, 0xD022, 0x3344:
  - with `BYTE_UNSTUFFER_RST_PASS_EN`: out 0x1100/10 with rstm=0, rstm_valid pulse; then 0x2233; hold=0x44.
  - without it: marker=0xD0, out 0x1100/10, done=1.
- Word 0x55FF, then flush: out 0x5500/10, err=1, done=1. Asserting rst during DRAIN clears all outputs to their reset values in the same cycle.

Source files
------------

// File: rtl/byte_unstuffer_if.sv
// Stream handshake bundle for byte_unstuffer: upstream words in, unstuffed words out, status.
// The rstm/rstm_valid pair exists only when BYTE_UNSTUFFER_RST_PASS_EN is defined.
interface byte_unstuffer_if;
  logic        ena_in;
  logic        rdy_out;
  logic [15:0] in;
  logic [1:0]  in_valid;
  logic        flush;
  logic        ena_out;
  logic        rdy_in;
  logic [15:0] out;
  logic [1:0]  out_valid;
  logic [7:0]  marker;
  logic        marker_valid;
  logic        done;
  logic        err;
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
  logic [2:0]  rstm;
  logic        rstm_valid;

  modport master (
    output ena_in, in, in_valid, flush, rdy_in,
    input  rdy_out, ena_out, out, out_valid, marker, marker_valid, done, err,
    input  rstm, rstm_valid
  );
  modport slave (
    input  ena_in, in, in_valid, flush, rdy_in,
    output rdy_out, ena_out, out, out_valid, marker, marker_valid, done, err,
    output rstm, rstm_valid
  );
`else
  modport master (
    output ena_in, in, in_valid, flush, rdy_in,
    input  rdy_out, ena_out, out, out_valid, marker, marker_valid, done, err
  );
  modport slave (
    input  ena_in, in, in_valid, flush, rdy_in,
    output rdy_out, ena_out, out, out_valid, marker, marker_valid, done, err
  );
`endif
endinterface

// File: rtl/byte_unstuffer.sv
// JPEG entropy-stream unstuffer: drops the 0x00 after each 0xFF, stops on a marker, repacks to 16 bits.
// Define BYTE_UNSTUFFER_RST_PASS_EN to let RST0..RST7 markers pass through without ending the stream.
module byte_unstuffer (
  input  logic             clk,
  input  logic             rst,
  byte_unstuffer_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  hold;
  logic        hold_v;
  logic        ff_pend;
  logic        tail_sent;

  logic        ena_out_q;
  logic [15:0] out_q;
  logic [1:0]  out_valid_q;
  logic [7:0]  marker_q;
  logic        marker_valid_q;
  logic        done_q;
  logic        err_q;
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
  logic [2:0]  rstm_q;
  logic        rstm_valid_q;
  logic [2:0]  rst_code;
`endif

  logic        rdy_out;
  logic        out_free;
  logic        accept;

  logic [7:0]  e0, e1;
  logic [1:0]  n_emit;
  logic        ff_nx;
  logic        mark_hit;
  logic [7:0]  mark_code;
  logic        rst_hit;
  logic [1:0]  avail;
  logic [7:0]  p0, p1, p2;

  // Per-byte scan of the incoming word, upper byte first.
  always_comb begin
    logic [7:0] b;
    logic       vld;
    // NOTE: blocking assignments here build a sequential chain of byte decisions within one cycle;
    // every variable gets a default first so no latch is inferred.
    e0        = 8'h00;
    e1        = 8'h00;
    n_emit    = 2'd0;
    ff_nx     = ff_pend;
    mark_hit  = 1'b0;
    mark_code = 8'h00;
    rst_hit   = 1'b0;
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
    rst_code  = 3'd0;
`endif
    for (int i = 0; i < 2; i++) begin
      b   = (i == 0) ? bus.in[15:8] : bus.in[7:0];
      vld = (i == 0) ? bus.in_valid[1] : bus.in_valid[0];
      if (vld && !mark_hit) begin
        if (ff_nx) begin
          if (b == 8'h00) begin
            if (n_emit == 2'd0) e0 = 8'hFF; else e1 = 8'hFF;
            n_emit = n_emit + 2'd1;
            ff_nx  = 1'b0;
          end else if (b != 8'hFF) begin
            ff_nx = 1'b0;
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
            if (b[7:3] == 5'b11010) begin
              rst_hit  = 1'b1;
              rst_code = b[2:0];
            end else begin
              mark_hit  = 1'b1;
              mark_code = b;
            end
`else
            mark_hit  = 1'b1;
            mark_code = b;
`endif
          end
        end else if (b == 8'hFF) begin
          ff_nx = 1'b1;
        end else begin
          if (n_emit == 2'd0) e0 = b; else e1 = b;
          n_emit = n_emit + 2'd1;
        end
      end
    end
  end

  // Ordered pool of bytes available for packing: held byte first, then this word's output.
  assign avail = {1'b0, hold_v} + n_emit;
  assign p0    = hold_v ? hold : e0;
  assign p1    = hold_v ? e0   : e1;
  assign p2    = e1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if ((accept && mark_hit) || (!accept && bus.flush)) state_nx = DRAIN;
      // With a tail word loaded, finish only once downstream has taken it.
      DRAIN:   if (tail_sent ? (ena_out_q && bus.rdy_in) : !hold_v) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    out_free = !ena_out_q || bus.rdy_in;
    rdy_out  = (state == RUN) && out_free;
    accept   = bus.ena_in && rdy_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold           <= 8'h00;
      hold_v         <= 1'b0;
      ff_pend        <= 1'b0;
      tail_sent      <= 1'b0;
      ena_out_q      <= 1'b0;
      out_q          <= 16'h0000;
      out_valid_q    <= 2'b00;
      marker_q       <= 8'h00;
      marker_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
      rstm_q         <= 3'd0;
      rstm_valid_q   <= 1'b0;
`endif
    end else begin
      if (ena_out_q && bus.rdy_in) ena_out_q <= 1'b0;
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
      rstm_valid_q <= 1'b0;
`endif
      case (state)
        RUN: begin
          if (accept) begin
            ff_pend <= ff_nx;
            if (mark_hit) begin
              marker_q       <= mark_code;
              marker_valid_q <= 1'b1;
            end
            if (rst_hit) begin
              // Restart interval: close out the partial word, then continue with what follows.
              if (hold_v) begin
                out_q       <= {hold, 8'h00};
                out_valid_q <= 2'b10;
                ena_out_q   <= 1'b1;
              end
              hold   <= e0;
              hold_v <= (n_emit != 2'd0);
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
              rstm_q       <= rst_code;
              rstm_valid_q <= 1'b1;
`endif
            end else if (avail >= 2'd2) begin
              out_q       <= {p0, p1};
              out_valid_q <= 2'b11;
              ena_out_q   <= 1'b1;
              hold        <= p2;
              hold_v      <= (avail == 2'd3);
            end else begin
              hold   <= p0;
              hold_v <= (avail == 2'd1);
            end
          end else if (bus.flush) begin
            if (ff_pend) err_q <= 1'b1;
            ff_pend <= 1'b0;
          end
        end
        DRAIN: begin
          if (!tail_sent && hold_v && out_free) begin
            out_q       <= {hold, 8'h00};
            out_valid_q <= 2'b10;
            ena_out_q   <= 1'b1;
            hold_v      <= 1'b0;
            tail_sent   <= 1'b1;
          end
          if (state_nx == DONE) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rdy_out      = rdy_out;
  assign bus.ena_out      = ena_out_q;
  assign bus.out          = out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.marker       = marker_q;
  assign bus.marker_valid = marker_valid_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
  assign bus.rstm         = rstm_q;
  assign bus.rstm_valid   = rstm_valid_q;
`endif

endmodule

// File: tb/tb_byte_unstuffer.sv
// Directed bench for byte_unstuffer: hand-computed output word sequences, markers, flush and reset.
// Inputs change 1 time unit after posedge; outputs are sampled away from the rising edge.
module tb_byte_unstuffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_unstuffer_if bus ();

  byte_unstuffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Every word taken by downstream, as {out_valid, out}.
  logic [17:0] got_q[$];
  always @(negedge clk)
    if (!rst && bus.ena_out && bus.rdy_in) got_q.push_back({bus.out_valid, bus.out});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] q_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 18'h3FFFF;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.ena_in   = 1'b0;
    bus.in       = 16'h0000;
    bus.in_valid = 2'b00;
    bus.flush    = 1'b0;
    bus.rdy_in   = 1'b1;
    idle(2);
    rst = 1'b0;
    got_q.delete();
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [15:0] w, input logic [1:0] v);
    int n = 0;
    bus.ena_in   = 1'b1;
    bus.in       = w;
    bus.in_valid = v;
    while (!bus.rdy_out && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.rdy_out) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.ena_in = 1'b0;
  endtask

  task automatic flush_until_done();
    int n = 0;
    bus.flush = 1'b1;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("flush_done", {31'd0, bus.done}, 32'd1);
    bus.flush = 1'b0;
    idle(2);
  endtask

  initial begin
    rst          = 1'b1;
    bus.ena_in   = 1'b0;
    bus.in       = 16'h0000;
    bus.in_valid = 2'b00;
    bus.flush    = 1'b0;
    bus.rdy_in   = 1'b1;
    #1;
    check("rst_ena_out", {31'd0, bus.ena_out}, 32'd0);
    check("rst_out", {16'd0, bus.out}, 32'd0);
    check("rst_out_valid", {30'd0, bus.out_valid}, 32'd0);
    check("rst_marker", {24'd0, bus.marker}, 32'd0);
    check("rst_flags", {28'd0, bus.marker_valid, bus.done, bus.err, dut.hold_v}, 32'd0);
    idle(2);
    rst = 1'b0;
    #1;
    check("rst_rdy_out", {31'd0, bus.rdy_out}, 32'd1);

    // Stuffed 0xFF reassembled across words, partial tail on flush.
    do_reset();
    send(16'h12FF, 2'b11);
    send(16'h0034, 2'b11);
    check("t1_latency_out", {16'd0, bus.out}, 32'h12FF);
    flush_until_done();
    check("t1_count", got_q.size(), 32'd2);
    check("t1_w0", {14'd0, q_at(0)}, 32'h312FF);
    check("t1_w1", {14'd0, q_at(1)}, 32'h23400);
    check("t1_status", {29'd0, bus.done, bus.marker_valid, bus.err}, 32'b100);
    check("t1_rdy_out_done", {31'd0, bus.rdy_out}, 32'd0);

    // Two stuffed pairs collapse into one full word.
    do_reset();
    send(16'hFF00, 2'b11);
    send(16'hFF00, 2'b11);
    idle(2);
    check("t2_count", got_q.size(), 32'd1);
    check("t2_w0", {14'd0, q_at(0)}, 32'h3FFFF);
    check("t2_hold_v", {31'd0, dut.hold_v}, 32'd0);

    // Marker split across words; trailing byte discarded.
    do_reset();
    send(16'hABFF, 2'b11);
    send(16'hD9EE, 2'b11);
    check("t3_marker_valid_next", {31'd0, bus.marker_valid}, 32'd1);
    check("t3_marker", {24'd0, bus.marker}, 32'h00D9);
    idle(5);
    check("t3_count", got_q.size(), 32'd1);
    check("t3_w0", {14'd0, q_at(0)}, 32'h2AB00);
    check("t3_done", {30'd0, bus.done, bus.rdy_out}, 32'b10);

    // Backpressure: first word must hold while the second waits.
    do_reset();
    bus.rdy_in = 1'b0;
    send(16'h0102, 2'b11);
    bus.ena_in   = 1'b1;
    bus.in       = 16'h0304;
    bus.in_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_out", {13'd0, bus.ena_out, bus.out_valid, bus.out}, {13'd0, 1'b1, 2'b11, 16'h0102});
      check("t4_rdy_out_low", {31'd0, bus.rdy_out}, 32'd0);
      idle(1);
    end
    bus.rdy_in = 1'b1;
    idle(1);
    bus.ena_in = 1'b0;
    idle(2);
    check("t4_count", got_q.size(), 32'd2);
    check("t4_w0", {14'd0, q_at(0)}, 32'h30102);
    check("t4_w1", {14'd0, q_at(1)}, 32'h30304);

    // RST0 marker: passes through with the option, terminates without it.
    do_reset();
    send(16'h11FF, 2'b11);
    send(16'hD022, 2'b11);
`ifdef BYTE_UNSTUFFER_RST_PASS_EN
    check("t5_rstm_pulse", {28'd0, bus.rstm_valid, bus.rstm}, 32'b1000);
    check("t5_partial", {13'd0, bus.ena_out, bus.out_valid, bus.out}, {13'd0, 1'b1, 2'b10, 16'h1100});
    send(16'h3344, 2'b11);
    idle(2);
    check("t5_rstm_cleared", {31'd0, bus.rstm_valid}, 32'd0);
    check("t5_count", got_q.size(), 32'd2);
    check("t5_w0", {14'd0, q_at(0)}, 32'h21100);
    check("t5_w1", {14'd0, q_at(1)}, 32'h32233);
    check("t5_hold", {23'd0, dut.hold_v, dut.hold}, 32'h144);
    check("t5_no_marker", {29'd0, bus.marker_valid, bus.done, bus.err}, 32'd0);
`else
    idle(5);
    check("t5_marker", {23'd0, bus.marker_valid, bus.marker}, 32'h1D0);
    check("t5_count", got_q.size(), 32'd1);
    check("t5_w0", {14'd0, q_at(0)}, 32'h21100);
    check("t5_done", {31'd0, bus.done}, 32'd1);
`endif

    // Dangling 0xFF at flush.
    do_reset();
    send(16'h55FF, 2'b11);
    flush_until_done();
    check("t6_count", got_q.size(), 32'd1);
    check("t6_w0", {14'd0, q_at(0)}, 32'h25500);
    check("t6_err_done", {30'd0, bus.err, bus.done}, 32'b11);

    // Async reset while DRAIN holds an untaken tail word.
    do_reset();
    bus.rdy_in = 1'b0;
    send(16'h55FF, 2'b11);
    bus.flush = 1'b1;
    idle(3);
    check("t7_tail_pending", {13'd0, bus.ena_out, bus.out_valid, bus.out}, {13'd0, 1'b1, 2'b10, 16'h5500});
    check("t7_err_before", {31'd0, bus.err}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_out", {13'd0, bus.ena_out, bus.out_valid, bus.out}, 32'd0);
    check("t7_rst_flags", {24'd0, bus.marker_valid, bus.done, bus.err, bus.marker[4:0]}, 32'd0);
    bus.flush = 1'b0;
    idle(1);
    rst = 1'b0;
    #1;
    check("t7_rdy_after_rst", {31'd0, bus.rdy_out}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
